// File: rtl/byte_lane_transfer_unit.sv
// Byte-serial transfer engine: moves up to one word between a word-wide request
// port and an 8-bit synchronous memory, with endian lane mapping and read extension.
module byte_lane_transfer_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int BIG_ENDIAN = 0,
    localparam int NB = DATA_WIDTH / 8,
    localparam int CW = $clog2(NB) + 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Op,
    input  logic [CW-1:0]         NumBytes,
    input  logic [ADDR_WIDTH-1:0] BaseAddr,
    input  logic [DATA_WIDTH-1:0] WrData,
    input  logic                  SignExt,
    input  logic [7:0]            MemOut,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic [7:0]            Mem_Data,
    output logic                  Mem_WR,
    output logic                  Mem_CS,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] RdData
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    localparam logic [CW-1:0] NB_C = CW'(NB);

    state_t                state, state_next;
    logic                  op_q;
    logic                  sext_q;
    logic [CW-1:0]         n_q;
    logic [CW-1:0]         k_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  cap_pend;
    logic [CW-1:0]         cap_lane;
    logic [DATA_WIDTH-1:0] acc;

    logic [CW-1:0]         n_eff;
    logic [CW-1:0]         lane;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0] rd_word;

    // Datapath: lane mapping, address generation and read-word assembly.
    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        n_eff      = (NumBytes == '0 || NumBytes > NB_C) ? NB_C : NumBytes;
        lane       = (BIG_ENDIAN != 0) ? (n_q - CW'(1) - k_q) : k_q;
        issue_addr = base_q + ADDR_WIDTH'(k_q);
        acc_next   = acc;
        if (cap_pend) begin
            acc_next[8*int'(cap_lane) +: 8] = MemOut;
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rd_word[i] = (i < 8*int'(n_q)) ? acc_next[i]
                                           : (sext_q & acc_next[8*int'(n_q)-1]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            op_q     <= 1'b0;
            sext_q   <= 1'b0;
            n_q      <= NB_C;
            k_q      <= '0;
            base_q   <= '0;
            wr_q     <= '0;
            addr_q   <= '0;
            cap_pend <= 1'b0;
            cap_lane <= '0;
            acc      <= '0;
            RdData   <= '0;
        end else begin
            state    <= state_next;
            cap_pend <= (state == XFER) && !op_q;
            cap_lane <= lane;
            acc      <= acc_next;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q   <= Op;
                        n_q    <= n_eff;
                        base_q <= BaseAddr;
                        wr_q   <= WrData;
                        sext_q <= SignExt;
                        k_q    <= '0;
                        acc    <= '0;
                    end
                end
                XFER: begin
                    k_q    <= k_q + CW'(1);
                    addr_q <= issue_addr;
                end
                DRAIN:   RdData <= rd_word;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        Mem_Data    = 8'h00;
        Mem_Address = addr_q;
        Busy        = (state != IDLE);
        Done        = (state == DONE);
        case (state)
            IDLE: begin
                if (Start) state_next = XFER;
            end
            XFER: begin
                Mem_CS      = 1'b0;
                Mem_WR      = op_q;
                Mem_Address = issue_addr;
                if (op_q) Mem_Data = wr_q[8*int'(lane) +: 8];
                if (k_q == n_q - CW'(1)) state_next = op_q ? DONE : DRAIN;
            end
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/byte_lane_transfer_unit.md
BYTE_LANE_TRANSFER_UNIT -- requirements
Module: byte_lane_transfer_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8 and at least 8; NB = DATA_WIDTH/8.
REQ-002 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-003 Parameter BIG_ENDIAN, default 0; 0 = byte k at lowest address, 1 = most significant byte at lowest address.
REQ-004 Clock  in  1  single clock; all state changes on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Start  in  1  request strobe, sampled only in IDLE.
REQ-007 Op  in  1  0 = read (memory -> RdData), 1 = write (WrData -> memory).
REQ-008 NumBytes  in  $clog2(NB)+1  bytes to transfer; 0 or >NB SHALL be treated as NB.
REQ-009 BaseAddr  in  ADDR_WIDTH  address of first byte.
REQ-010 WrData  in  DATA_WIDTH  write word.
REQ-011 SignExt  in  1  read result: 1 = sign-extend, 0 = zero-extend.
REQ-012 MemOut  in  8  memory read byte, valid one cycle after the address is presented with chip select active.
REQ-013 Mem_Address  out  ADDR_WIDTH  byte address.
REQ-014 Mem_Data  out  8  write byte.
REQ-015 Mem_WR  out  1  1 = write, 0 = read.
REQ-016 Mem_CS  out  1  active-low chip select.
REQ-017 Busy  out  1  transfer in progress.
REQ-018 Done  out  1  single-cycle completion pulse.
REQ-019 RdData  out  DATA_WIDTH  assembled read word.

Function
REQ-020 FSM states SHALL be IDLE, XFER, DRAIN, DONE.
REQ-021 IDLE: Start=1 SHALL latch Op, effective count N, BaseAddr, WrData and SignExt, clear byte index k, and enter XFER next cycle.
REQ-022 Start SHALL be ignored in XFER, DRAIN and DONE, including the DONE cycle itself.
REQ-023 XFER: each cycle SHALL issue byte k with Mem_CS=0 and Mem_Address = BaseAddr+k, modulo 2^ADDR_WIDTH (wraps, no error).
REQ-024 Write lane select: BIG_ENDIAN=0 -> byte k of latched WrData; BIG_ENDIAN=1 -> byte N-1-k; Mem_WR=1 in every XFER cycle.
REQ-025 Read: Mem_WR=0; MemOut SHALL be captured in the cycle after each issue and placed in the lane given by the REQ-024 mapping.
REQ-026 After k=N-1, a write SHALL go to DONE and a read SHALL go to DRAIN (one cycle, Mem_CS=1, capture last byte), then to DONE.
REQ-027 DONE: Done=1 for exactly one cycle, then IDLE.
REQ-028 Latency from the Start cycle t: write bytes issued at t+1..t+N, Done at t+N+1; read bytes issued at t+1..t+N, Done at t+N+2.
REQ-029 RdData SHALL update only in the read DONE cycle: low 8N bits assembled; upper bits equal bit 8N-1 if SignExt=1, else 0. RdData holds until the next read completes; writes do not alter it.
REQ-030 Busy SHALL be 1 in XFER, DRAIN and DONE, 0 in IDLE.
REQ-031 Outside XFER: Mem_CS=1, Mem_WR=0, Mem_Data=0; Mem_Address holds its last value.

Reset
REQ-032 Reset=1 at any edge, including mid-transfer, SHALL force IDLE, Busy=0, Done=0, Mem_CS=1, Mem_WR=0, Mem_Data=0, Mem_Address=0, RdData=0 and k=0; Reset SHALL take priority over Start.
REQ-033 A transfer aborted by reset SHALL NOT issue further memory cycles or a Done pulse.

Verification
REQ-034 Write, DATA_WIDTH=32, little-endian: Start with Op=1, N=4, BaseAddr=0x0010, WrData=0xA1B2C3D4 -> writes 0xD4@0x10, 0xC3@0x11, 0xB2@0x12, 0xA1@0x13 at t+1..t+4; Done at t+5.
REQ-035 Read with sign extension, N=2, memory 0x40=0x34, 0x41=0x92, SignExt=1 -> RdData=0xFFFF9234 and Done at t+4; repeated with SignExt=0 -> 0x00009234.
REQ-036 Big-endian and wrap-around: BIG_ENDIAN=1, Op=1, N=4, BaseAddr=0xFFFE, WrData=0x11223344 -> 0x11@0xFFFE, 0x22@0xFFFF, 0x33@0x0000, 0x44@0x0001.
REQ-037 Start pulsed during XFER and in the DONE cycle -> ignored: no extra memory cycles and one Done pulse only; NumBytes=0 -> full 4-byte transfer.
REQ-038 Reset asserted at t+2 of a 4-byte write -> only 0x10 and 0x11 written; next cycle all outputs at reset values and Done never pulses.
